// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, parity bit, stop bit.
// One bit per clock; a parallel word is accepted on load while the line is idle.
module parity_serial_tx #(
    parameter int WIDTH = 8,
    parameter int ODD   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_par;
    logic             w_par_nxt;
    logic             r_sout;
    logic             w_sout_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;

    assign w_accept = load && (r_state == S_IDLE);
    assign ready    = (r_state == S_IDLE);
    assign sout     = r_sout;
    assign busy     = r_busy;
    assign done     = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_sout  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_par   <= w_par_nxt;
            r_sout  <= w_sout_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_STOP);
        end
    end

    // Line value is computed for the state being entered, so sout lines up
    // with the state register on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;
        w_sout_nxt  = r_sout;
        unique case (r_state)
            S_IDLE: begin
                w_sout_nxt = 1'b1;
                if (w_accept) begin
                    w_shreg_nxt = data;
                    w_par_nxt   = (ODD != 0) ? ~^data : ^data;
                    w_state_nxt = S_START;
                    w_sout_nxt  = 1'b0;
                end
            end
            S_START: begin
                w_state_nxt = S_DATA;
                w_cnt_nxt   = '0;
                w_sout_nxt  = r_shreg[0];
                w_shreg_nxt = r_shreg >> 1;
            end
            S_DATA: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_PAR;
                    w_sout_nxt  = r_par;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_sout_nxt  = r_shreg[0];
                    w_shreg_nxt = r_shreg >> 1;
                end
            end
            S_PAR: begin
                w_state_nxt = S_STOP;
                w_sout_nxt  = 1'b1;
            end
            S_STOP: begin
                w_state_nxt = S_IDLE;
                w_sout_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sout_nxt  = 1'b1;
            end
        endcase
    end

endmodule
